// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the memory-stage load/store unit:
//   - RV32I funct3 width/sign encodings used by loads and stores
//   - FSM state type (IDLE, RMW_WR)
//   - addr_in_range(): true when a 4-byte window starting at the address
//     stays inside a 2^aw byte memory
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } lsu_state_e;

    // The memory always reads 4 bytes, so every access size is limited to
    // addr <= 2^aw - 4. Computed in 33 bits so the limit itself never wraps.
    function automatic logic addr_in_range(input logic [31:0] a, input int aw);
        logic [32:0] lim;
        lim = (33'd1 << aw) - 33'd4;
        return ({1'b0, a} <= lim);
    endfunction

endpackage

// File: rtl/load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
// Purely combinational load-result formatter. Picks the low byte, halfword or
// word of the raw memory read and sign- or zero-extends it to 32 bits.
// Ports:
//   funct3_i  in  3   RV32I load funct3
//   data_i    in  32  raw memory read data (byte at the access address in [7:0])
//   data_o    out 32  extended load result
// Illegal funct3 values fall through to the word case; the caller rejects them.
// -----------------------------------------------------------------------------
module load_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = data_i;
        case (funct3_i)
            F3_B:    data_o = {{24{data_i[7]}}, data_i[7:0]};
            F3_H:    data_o = {{16{data_i[15]}}, data_i[15:0]};
            F3_BU:   data_o = {24'h0, data_i[7:0]};
            F3_HU:   data_o = {16'h0, data_i[15:0]};
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Memory-stage load/store unit for the pipelined RV32I core. Loads, SW and
// rejected accesses complete in one cycle. SB/SH become a two-cycle
// read-modify-write so the untouched bytes of the 4-byte memory word survive.
//
// Request handshake: a request is presented with req_valid=1 and held stable
// by the pipeline for every cycle in which stall=1; it is consumed in the
// first cycle where stall=0. During RMW_WR the pipeline still presents the
// same SB/SH request, and this unit ignores it.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   req_valid/req_write request present / 1 = store
//   funct3, addr, wdata RV32I width field, byte address, store data
//   stall               combinational hold request for the MEM stage
//   rdata, done, fault  registered load result, completion / reject pulses
//   mem_we/addr/din     data-memory write enable, byte address, write data
//   mem_dout            combinational memory read data at mem_addr
//   dbg_state           current FSM state for observation
// -----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              fault,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout,
    output lsu_state_e        dbg_state
);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [31:0]       m_q, m_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              fault_q, fault_d;

    logic [31:0]       ext_data;
    logic              legal;
    logic              we_c;

    load_extend u_load_extend (
        .funct3_i (funct3),
        .data_i   (mem_dout),
        .data_o   (ext_data)
    );

    // Legality depends only on request fields, never on mem_dout, so stall
    // has no path from the memory read data.
    always_comb begin
        legal = 1'b0;
        if (addr_in_range(32'(addr), ADDR_W)) begin
            if (req_write)
                legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
            else
                legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                        (funct3 == F3_BU) || (funct3 == F3_HU);
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        m_d      = m_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;
        fault_d  = 1'b0;
        stall    = 1'b0;
        we_c     = 1'b0;
        mem_addr = addr;
        mem_din  = 32'h0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (!legal) begin
                        fault_d = 1'b1;
                    end else if (!req_write) begin
                        rdata_d = ext_data;
                        done_d  = 1'b1;
                    end else if (funct3 == F3_W) begin
                        we_c    = 1'b1;
                        mem_din = wdata;
                        done_d  = 1'b1;
                    end else begin
                        // SB/SH: capture the merged word now, write it next cycle.
                        stall   = 1'b1;
                        a_d     = addr;
                        m_d     = (funct3 == F3_B) ? {mem_dout[31:8], wdata[7:0]}
                                                   : {mem_dout[31:16], wdata[15:0]};
                        state_d = RMW_WR;
                    end
                end
            end
            RMW_WR: begin
                mem_addr = a_q;
                mem_din  = m_q;
                we_c     = 1'b1;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset must kill a pending merged write within the same cycle, before
    // the next clock edge can commit it.
    assign mem_we = we_c & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            m_q     <= 32'h0;
            rdata_q <= 32'h0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            m_q     <= m_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

    assign rdata     = rdata_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign dbg_state = state_q;

endmodule
